// File: rtl/button_event_arbiter_if.sv
// rtl/button_event_arbiter_if.sv - valid/ready event port between arbiter and consumer
interface button_event_arbiter_if #(
   parameter int ID_W = 3
);
   logic            EV_VALID;
   logic            EV_READY;
   logic [ID_W-1:0] EV_ID;
   logic            EV_REPEAT;

   modport master (output EV_VALID, output EV_ID, output EV_REPEAT, input EV_READY);
   modport slave  (input EV_VALID, input EV_ID, input EV_REPEAT, output EV_READY);
endinterface

// File: rtl/button_event_arbiter.sv
// rtl/button_event_arbiter.sv - latches debounced button pulses and serialises them round-robin
module button_event_arbiter #(
   parameter int N_BTN  = 5,
   parameter int ID_W   = 3,
   parameter int DROP_W = 8
) (
   input  logic                  CLK,
   input  logic                  RESET,
   input  logic                  ENABLE,
   input  logic [N_BTN-1:0]      SCEN,
   input  logic [N_BTN-1:0]      MCEN,
   output logic [N_BTN-1:0]      PENDING,
   output logic [DROP_W-1:0]     DROP_CNT,
   button_event_arbiter_if.master ev
);

   typedef enum logic {IDLE, PRESENT} state_t;

   state_t              state, state_n;
   logic [N_BTN-1:0]    pending_q, pending_n, rep_q, rep_n, clr_vec, drop_vec;
   logic [ID_W-1:0]     rr_ptr, rr_ptr_n, ev_id_q, ev_id_n, winner, off;
   logic                ev_rep_q, ev_rep_n, found;
   logic [2*N_BTN-1:0]  rot;
   logic [ID_W:0]       wsum;
   logic [DROP_W:0]     drop_sum;
   logic [DROP_W-1:0]   drop_n;

   assign ev.EV_VALID  = (state == PRESENT);
   assign ev.EV_ID     = ev_id_q;
   assign ev.EV_REPEAT = ev_rep_q;
   assign PENDING      = pending_q;

   // Rotating the doubled vector lets the scan start at rr_ptr and wrap naturally.
   always_comb begin
      rot   = {pending_q, pending_q} >> rr_ptr;
      found = 1'b0;
      off   = '0;
      for (int k = 0; k < N_BTN; k++) begin
         if (!found && rot[k]) begin
            found = 1'b1;
            off   = ID_W'(k);
         end
      end
      wsum = {1'b0, rr_ptr} + {1'b0, off};
      if (wsum >= (ID_W+1)'(N_BTN))
         wsum = wsum - (ID_W+1)'(N_BTN);
      winner = wsum[ID_W-1:0];
   end

   always_comb begin
      state_n  = state;
      ev_id_n  = ev_id_q;
      ev_rep_n = ev_rep_q;
      rr_ptr_n = rr_ptr;
      clr_vec  = '0;
      case (state)
         IDLE: begin
            if (|pending_q) begin
               ev_id_n  = winner;
               ev_rep_n = rep_q[winner];
               state_n  = PRESENT;
            end
         end
         PRESENT: begin
            if (ev.EV_READY) begin
               clr_vec  = N_BTN'(1) << ev_id_q;
               rr_ptr_n = (ev_id_q == ID_W'(N_BTN-1)) ? '0 : ev_id_q + ID_W'(1);
               state_n  = IDLE;
            end
         end
         default: state_n = IDLE;
      endcase
   end

   // A pulse arriving while its flag is being cleared re-arms the flag instead of dropping.
   always_comb begin
      pending_n = pending_q & ~clr_vec;
      rep_n     = rep_q;
      drop_vec  = '0;
      for (int i = 0; i < N_BTN; i++) begin
         if (ENABLE && (SCEN[i] || MCEN[i])) begin
            if (!pending_q[i] || clr_vec[i]) begin
               pending_n[i] = 1'b1;
               rep_n[i]     = !SCEN[i];
            end else begin
               if (SCEN[i])
                  rep_n[i] = 1'b0;
               drop_vec[i] = 1'b1;
            end
         end
      end
      drop_sum = {1'b0, DROP_CNT};
      for (int i = 0; i < N_BTN; i++)
         drop_sum = drop_sum + (DROP_W+1)'(drop_vec[i]);
      drop_n = drop_sum[DROP_W] ? '1 : drop_sum[DROP_W-1:0];
   end

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET)
         state <= IDLE;
      else
         state <= state_n;
   end

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         pending_q <= '0;
         rep_q     <= '0;
         rr_ptr    <= '0;
         ev_id_q   <= '0;
         ev_rep_q  <= 1'b0;
         DROP_CNT  <= '0;
      end else begin
         pending_q <= pending_n;
         rep_q     <= rep_n;
         rr_ptr    <= rr_ptr_n;
         ev_id_q   <= ev_id_n;
         ev_rep_q  <= ev_rep_n;
         DROP_CNT  <= drop_n;
      end
   end

endmodule

// File: tb/tb_button_event_arbiter.sv
// tb/tb_button_event_arbiter.sv - directed self-checking bench for button_event_arbiter
module tb_button_event_arbiter;

   logic       CLK = 1'b0;
   logic       RESET = 1'b1;
   logic       ENABLE = 1'b1;
   logic [4:0] SCEN = '0;
   logic [4:0] MCEN = '0;
   logic [4:0] PENDING;
   logic [7:0] DROP_CNT;
   int         checks = 0;
   int         errors = 0;

   button_event_arbiter_if #(.ID_W(3)) ev_if ();

   button_event_arbiter #(.N_BTN(5), .ID_W(3), .DROP_W(8)) dut (
      .CLK      (CLK),
      .RESET    (RESET),
      .ENABLE   (ENABLE),
      .SCEN     (SCEN),
      .MCEN     (MCEN),
      .PENDING  (PENDING),
      .DROP_CNT (DROP_CNT),
      .ev       (ev_if)
   );

   always #5 CLK = ~CLK;

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic do_reset();
      RESET = 1'b1;
      step();
      step();
      RESET = 1'b0;
      step();
   endtask

   task automatic wait_valid(input string tag);
      for (int n = 0; n < 10 && !ev_if.EV_VALID; n++)
         step();
      check({tag, "_valid"}, ev_if.EV_VALID, 1);
   endtask

   task automatic expect_event(input string tag, input int id, input int rep);
      wait_valid(tag);
      check({tag, "_id"}, ev_if.EV_ID, id);
      check({tag, "_rep"}, ev_if.EV_REPEAT, rep);
      step();
   endtask

   initial begin
      ev_if.EV_READY = 1'b0;
      do_reset();
      check("rst_valid", ev_if.EV_VALID, 0);
      check("rst_id", ev_if.EV_ID, 0);
      check("rst_rep", ev_if.EV_REPEAT, 0);
      check("rst_pending", PENDING, 0);
      check("rst_drop", DROP_CNT, 0);

      // single press, exact two-cycle latency
      ev_if.EV_READY = 1'b1;
      SCEN = 5'b00100;
      step();
      SCEN = '0;
      check("t1_pend", PENDING, 5'b00100);
      check("t1_valid_early", ev_if.EV_VALID, 0);
      step();
      check("t1_valid", ev_if.EV_VALID, 1);
      check("t1_id", ev_if.EV_ID, 2);
      check("t1_rep", ev_if.EV_REPEAT, 0);
      step();
      check("t1_valid_after", ev_if.EV_VALID, 0);
      check("t1_pend_after", PENDING, 0);

      // round-robin ordering
      do_reset();
      ev_if.EV_READY = 1'b1;
      SCEN = 5'b10101;
      step();
      SCEN = '0;
      expect_event("t2a", 0, 0);
      expect_event("t2b", 2, 0);
      expect_event("t2c", 4, 0);
      SCEN = 5'b10001;
      step();
      SCEN = '0;
      expect_event("t2d", 0, 0);
      expect_event("t2e", 4, 0);
      SCEN = 5'b00001;
      step();
      SCEN = '0;
      expect_event("t2f", 0, 0);
      SCEN = 5'b10010;
      step();
      SCEN = '0;
      expect_event("t2g", 1, 0);
      expect_event("t2h", 4, 0);

      // stall holds presented event stable
      ev_if.EV_READY = 1'b0;
      SCEN = 5'b01000;
      step();
      SCEN = '0;
      wait_valid("t3");
      check("t3_id", ev_if.EV_ID, 3);
      for (int n = 0; n < 20; n++) begin
         step();
         check("t3_hold_valid", ev_if.EV_VALID, 1);
         check("t3_hold_id", ev_if.EV_ID, 3);
         check("t3_hold_rep", ev_if.EV_REPEAT, 0);
      end
      ev_if.EV_READY = 1'b1;
      step();
      check("t3_valid_after", ev_if.EV_VALID, 0);
      check("t3_pend_after", PENDING, 0);

      // repeat storm saturates the drop counter
      do_reset();
      ev_if.EV_READY = 1'b0;
      MCEN = 5'b00010;
      for (int n = 0; n < 300; n++)
         step();
      MCEN = '0;
      check("t4_valid", ev_if.EV_VALID, 1);
      check("t4_id", ev_if.EV_ID, 1);
      check("t4_rep", ev_if.EV_REPEAT, 1);
      check("t4_drop", DROP_CNT, 255);
      check("t4_pend", PENDING, 5'b00010);
      ev_if.EV_READY = 1'b1;
      step();
      step();
      check("t4_no_extra", ev_if.EV_VALID, 0);
      check("t4_pend_after", PENDING, 0);

      // press upgrades a pending repeat
      do_reset();
      ev_if.EV_READY = 1'b0;
      SCEN = 5'b00001;
      step();
      SCEN = '0;
      wait_valid("t5_busy");
      MCEN = 5'b00010;
      step();
      MCEN = '0;
      SCEN = 5'b00010;
      step();
      SCEN = '0;
      check("t5_drop", DROP_CNT, 1);
      check("t5_pend", PENDING, 5'b00011);
      ev_if.EV_READY = 1'b1;
      expect_event("t5a", 0, 0);
      expect_event("t5b", 1, 0);

      // pulse coinciding with its own clear re-arms without a drop
      ev_if.EV_READY = 1'b0;
      SCEN = 5'b00100;
      step();
      SCEN = '0;
      wait_valid("t5c");
      check("t5c_id", ev_if.EV_ID, 2);
      ev_if.EV_READY = 1'b1;
      SCEN = 5'b00100;
      step();
      SCEN = '0;
      check("t5c_pend", PENDING, 5'b00100);
      check("t5c_drop", DROP_CNT, 1);
      check("t5c_valid", ev_if.EV_VALID, 0);
      expect_event("t5d", 2, 0);

      // ENABLE low ignores pulses
      ENABLE = 1'b0;
      SCEN = 5'b01000;
      step();
      SCEN = '0;
      ENABLE = 1'b1;
      check("t5e_pend", PENDING, 0);
      step();
      check("t5e_valid", ev_if.EV_VALID, 0);

      // asynchronous reset mid-handshake
      ev_if.EV_READY = 1'b0;
      SCEN = 5'b10000;
      step();
      SCEN = '0;
      wait_valid("t6");
      RESET = 1'b1;
      #1;
      check("t6_valid", ev_if.EV_VALID, 0);
      check("t6_id", ev_if.EV_ID, 0);
      check("t6_rep", ev_if.EV_REPEAT, 0);
      check("t6_pend", PENDING, 0);
      check("t6_drop", DROP_CNT, 0);
      step();
      RESET = 1'b0;
      ev_if.EV_READY = 1'b1;
      step();
      step();
      step();
      check("t6_no_stale", ev_if.EV_VALID, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
